imem_boot_ctrl: RTL

//  Boot-time sequencer for the writable 128x32 instruction memory. Receives a framed program
//  as a byte stream (UART RX side), packs bytes into 32-bit instructions, writes them word by

---
 rtl/imem_boot_pkg.sv | 22 ++
 rtl/boot_word_packer.sv | 40 ++++
 rtl/imem_boot_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_pkg;

   typedef enum logic [2:0] {
      ST_SYNC  = 3'd0,
      ST_COUNT = 3'd1,
      ST_DATA  = 3'd2,
      ST_WRITE = 3'd3,
      ST_CHECK = 3'd4,
      ST_RUN   = 3'd5,
      ST_ERR   = 3'd6
   } state_t;

   localparam logic [7:0] SYNC_BYTE      = 8'hA5;
   localparam int         BYTES_PER_WORD = 4;

   // A count byte of zero stands for a full memory image.
   function automatic logic [7:0] decode_count(input logic [7:0] raw, input logic [7:0] full);
      return (raw == 8'd0) ? full : raw;
   endfunction

endpackage

// File: rtl/boot_word_packer.sv
// Packs a little-endian byte stream into 32-bit words and keeps a running XOR
// of every data byte seen since the last clear.
module boot_word_packer
   import imem_boot_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word_out,
   output logic        word_done,
   output logic [7:0]  csum
);

   logic [1:0]  idx;
   logic [31:0] word_q;
   logic [7:0]  csum_q;

   // Byte lane register, byte index and checksum; clr restarts a frame.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         idx    <= 2'd0;
         word_q <= 32'd0;
         csum_q <= 8'd0;
      end else if (byte_en) begin
         word_q[8*idx +: 8] <= byte_in;
         idx                <= idx + 2'd1;
         csum_q             <= csum_q ^ byte_in;
      end
   end

   // The fourth byte of a word completes it on this clock edge.
   always_comb begin
      word_done = byte_en && (idx == 2'(BYTES_PER_WORD - 1));
      word_out  = word_q;
      csum      = csum_q;
   end

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot sequencer: receives a framed program over a byte stream, writes it into
// the instruction memory and keeps the CPU in reset until the image checks out.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_SYNC  | hunting for the 0xA5 sync byte, other bytes dropped
//  ST_COUNT | next byte is the word count (0 = full depth)
//  ST_DATA  | collecting the four bytes of the current word
//  ST_WRITE | one-cycle imem write of the packed word
//  ST_CHECK | next byte is compared against the running XOR
//  ST_RUN   | image accepted (or ROM boot), CPU out of reset
//  ST_ERR   | bad count or checksum, CPU held in reset
module imem_boot_ctrl
   import imem_boot_pkg::*;
#(
   parameter int N             = 32,
   parameter int ADDR_W        = 7,
   parameter int DEPTH         = 128,
   parameter int BOOT_ON_RESET = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   input  logic              load_req,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [N-1:0]      imem_wdata,
   output logic              cpu_reset,
   output logic              loaded,
   output logic              error,
   output logic [7:0]        word_count
);

   state_t            state, state_nxt;
   logic              accept;
   logic              sync_hit;
   logic              check_ok;
   logic              last_word;
   logic [7:0]        count_q;
   logic [ADDR_W-1:0] widx;
   logic [7:0]        wcnt;
   logic              loaded_q;
   logic [31:0]       word_out;
   logic              word_done;
   logic [7:0]        csum;

   assign accept    = rx_valid && rx_ready;
   assign sync_hit  = (state == ST_SYNC) && accept && (rx_data == SYNC_BYTE);
   assign check_ok  = (state == ST_CHECK) && accept && (rx_data == csum);
   assign last_word = (wcnt == (count_q - 8'd1));

   boot_word_packer u_packer (
      .clk       (clk),
      .reset     (reset),
      .clr       (sync_hit),
      .byte_en   ((state == ST_DATA) && accept),
      .byte_in   (rx_data),
      .word_out  (word_out),
      .word_done (word_done),
      .csum      (csum)
   );

   // State register; a ROM-booted build comes out of reset already running.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= (BOOT_ON_RESET != 0) ? ST_SYNC : ST_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_SYNC:  if (sync_hit) state_nxt = ST_COUNT;
         ST_COUNT: begin
            if (accept) begin
               if ((rx_data != 8'd0) && (rx_data > 8'(DEPTH))) state_nxt = ST_ERR;
               else                                            state_nxt = ST_DATA;
            end
         end
         ST_DATA:  if (word_done) state_nxt = ST_WRITE;
         ST_WRITE: state_nxt = last_word ? ST_CHECK : ST_DATA;
         ST_CHECK: begin
            if (accept) state_nxt = (rx_data == csum) ? ST_RUN : ST_ERR;
         end
         ST_RUN:   if (load_req) state_nxt = ST_SYNC;
         ST_ERR:   if (load_req) state_nxt = ST_SYNC;
         default:  state_nxt = ST_SYNC;
      endcase
   end

   // Word index, word count, latched frame length and loaded flag.
   // The index saturates so a full-depth frame can never wrap the address.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q  <= 8'd0;
         widx     <= '0;
         wcnt     <= 8'd0;
         loaded_q <= 1'b0;
      end else begin
         if (sync_hit) begin
            widx <= '0;
            wcnt <= 8'd0;
         end
         if ((state == ST_COUNT) && accept) begin
            count_q <= decode_count(rx_data, 8'(DEPTH));
         end
         if (state == ST_WRITE) begin
            if (widx != ADDR_W'(DEPTH - 1)) widx <= widx + 1'b1;
            wcnt <= wcnt + 8'd1;
         end
         loaded_q <= (state_nxt == ST_RUN) && (loaded_q || check_ok);
      end
   end

   // Moore outputs derived from the state and the datapath registers.
   always_comb begin
      rx_ready   = (state == ST_SYNC) || (state == ST_COUNT) ||
                   (state == ST_DATA) || (state == ST_CHECK);
      imem_we    = (state == ST_WRITE);
      imem_waddr = widx;
      imem_wdata = N'(word_out);
      cpu_reset  = (state != ST_RUN);
      loaded     = loaded_q;
      error      = (state == ST_ERR);
      word_count = wcnt;
   end

endmodule
